// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : op-code constants, sequencer state encoding, default datapath width
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_watchdog_counter.sv
`default_nettype none
// ============================================================================
// alu_watchdog_counter : saturating cycle counter, expired in cycle TIMEOUT_CYCLES
// Rev 1.0
// ============================================================================
module alu_watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_d, count_q;

  // count_q holds the number of enabled cycles already elapsed, so the
  // TIMEOUT_CYCLES-th enabled cycle is the one that sees count_q == LAST.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/alu_io_sequencer.sv
`default_nettype none
// ============================================================================
// alu_io_sequencer : command/result sequencer around the ALU control unit
// Rev 1.0
// ============================================================================
module alu_io_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [2*WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0]   cmd_y,
  output logic               alu_begin,
  output logic [1:0]         alu_op_code,
  output logic [WIDTH-1:0]   inbus,
  input  logic               alu_load_a,
  input  logic               alu_load_q,
  input  logic               alu_load_m,
  input  logic               alu_push_a,
  input  logic               alu_push_q,
  input  logic [WIDTH-1:0]   outbus,
  input  logic               alu_end,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_lo,
  output logic [WIDTH-1:0]   res_hi,
  output logic               res_err,
  output logic               res_timeout
);

  seq_state_t         state_d, state_q;
  logic [1:0]         op_d, op_q, op_code_d, op_code_q;
  logic [2*WIDTH-1:0] x_d, x_q;
  logic [WIDTH-1:0]   y_d, y_q, res_lo_d, res_lo_q, res_hi_d, res_hi_q;
  logic               res_err_d, res_err_q, res_timeout_d, res_timeout_q;
  logic               proto_err_d, proto_err_q;
  logic               seen_a_d, seen_a_q, seen_q_d, seen_q_q;
  logic               cmd_ready_d, cmd_ready_q, begin_d, begin_q, valid_d, valid_q;
  logic               wd_clr, wd_en, wd_expired;
  logic               is_addsub, is_mul, is_div, bad_load, complete;
  logic [WIDTH-1:0]   inbus_val;

  assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_mul    = (op_q == OP_MUL);
  assign is_div    = (op_q == OP_DIV);

  assign bad_load = (alu_load_a && alu_load_q) || (alu_load_a && alu_load_m) ||
                    (alu_load_q && alu_load_m) ||
                    (alu_load_q && is_addsub) || (alu_load_a && is_mul);

  // Operand mux follows A>Q>M priority; an illegal strobe drives zero.
  always_comb begin
    inbus_val = '0;
    if (state_q == ST_RUN) begin
      if (alu_load_a) begin
        if (!is_mul) inbus_val = is_div ? x_q[2*WIDTH-1:WIDTH] : x_q[WIDTH-1:0];
      end else if (alu_load_q) begin
        if (!is_addsub) inbus_val = x_q[WIDTH-1:0];
      end else if (alu_load_m) begin
        inbus_val = y_q;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    op_code_d     = op_code_q;
    x_d           = x_q;
    y_d           = y_q;
    res_lo_d      = res_lo_q;
    res_hi_d      = res_hi_q;
    res_err_d     = res_err_q;
    res_timeout_d = res_timeout_q;
    proto_err_d   = proto_err_q;
    seen_a_d      = seen_a_q;
    seen_q_d      = seen_q_q;
    complete      = 1'b0;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d          = cmd_op;
          x_d           = cmd_x;
          y_d           = cmd_y;
          res_lo_d      = '0;
          res_hi_d      = '0;
          res_err_d     = 1'b0;
          res_timeout_d = 1'b0;
          proto_err_d   = 1'b0;
          seen_a_d      = 1'b0;
          seen_q_d      = 1'b0;
          if ((cmd_op == OP_DIV) && (cmd_y == '0)) begin
            state_d   = ST_DONE;
            res_err_d = 1'b1;
          end else begin
            state_d   = ST_START;
            op_code_d = cmd_op;
          end
        end
      end
      ST_START: begin
        state_d = ST_RUN;
        wd_clr  = 1'b1;
      end
      ST_RUN: begin
        wd_en = 1'b1;
        if (bad_load) proto_err_d = 1'b1;
        if (alu_push_a) begin
          if (seen_a_q) proto_err_d = 1'b1;
          seen_a_d = 1'b1;
          if (is_addsub) res_lo_d = outbus;
          else           res_hi_d = outbus;
        end
        if (alu_push_q) begin
          if (seen_q_q) proto_err_d = 1'b1;
          seen_q_d = 1'b1;
          res_lo_d = outbus;
        end
        // Completeness uses the post-capture flags so a push with END counts.
        complete = is_addsub ? seen_a_d : (seen_a_d && seen_q_d);
        if (alu_end) begin
          state_d   = ST_DONE;
          res_err_d = proto_err_d || !complete;
        end else if (wd_expired) begin
          state_d       = ST_DONE;
          res_err_d     = 1'b1;
          res_timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d       = ST_IDLE;
          op_code_d     = OP_ADD;
          res_err_d     = 1'b0;
          res_timeout_d = 1'b0;
          proto_err_d   = 1'b0;
          seen_a_d      = 1'b0;
          seen_q_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    begin_d     = (state_d == ST_START);
    valid_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_ADD;
      op_code_q     <= OP_ADD;
      x_q           <= '0;
      y_q           <= '0;
      res_lo_q      <= '0;
      res_hi_q      <= '0;
      res_err_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      proto_err_q   <= 1'b0;
      seen_a_q      <= 1'b0;
      seen_q_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      begin_q       <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      op_code_q     <= op_code_d;
      x_q           <= x_d;
      y_q           <= y_d;
      res_lo_q      <= res_lo_d;
      res_hi_q      <= res_hi_d;
      res_err_q     <= res_err_d;
      res_timeout_q <= res_timeout_d;
      proto_err_q   <= proto_err_d;
      seen_a_q      <= seen_a_d;
      seen_q_q      <= seen_q_d;
      cmd_ready_q   <= cmd_ready_d;
      begin_q       <= begin_d;
      valid_q       <= valid_d;
    end
  end

  alu_watchdog_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign cmd_ready   = cmd_ready_q;
  assign alu_begin   = begin_q;
  assign alu_op_code = op_code_q;
  assign inbus       = inbus_val;
  assign res_valid   = valid_q;
  assign res_lo      = res_lo_q;
  assign res_hi      = res_hi_q;
  assign res_err     = res_err_q;
  assign res_timeout = res_timeout_q;

endmodule
`default_nettype wire
